// File: rtl/booth_product_accumulator_if.sv
// ============================================================================
// Module      : booth_product_accumulator_if
// Description : Product-in / frame-sum-out handshake bundle for the Booth
//               product accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface booth_product_accumulator_if #(
    parameter int PW = 8,
    parameter int AW = 16,
    parameter int CW = 3
) ();
    logic                 prod_valid;
    logic                 prod_ready;
    logic signed [PW-1:0] prod_data;
    logic                 prod_last;
    logic                 acc_valid;
    logic                 acc_ready;
    logic signed [AW-1:0] acc_data;
    logic        [CW-1:0] acc_count;
    logic                 acc_ovf;

    modport master (
        output prod_valid, prod_data, prod_last, acc_ready,
        input  prod_ready, acc_valid, acc_data, acc_count, acc_ovf
    );

    modport slave (
        input  prod_valid, prod_data, prod_last, acc_ready,
        output prod_ready, acc_valid, acc_data, acc_count, acc_ovf
    );
endinterface

`default_nettype wire

// File: rtl/booth_product_accumulator.sv
// ============================================================================
// Module      : booth_product_accumulator
// Description : Sums frames of signed Booth products into a wide accumulator.
//               Optional macro BOOTH_ACC_SAT_EN clamps on overflow instead of
//               wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_product_accumulator #(
    parameter int PW        = 8,
    parameter int AW        = 16,
    parameter int FRAME_LEN = 4,
    parameter int CW        = $clog2(FRAME_LEN + 1)
) (
    input  wire logic                          clk,
    input  wire logic                          rst,
    booth_product_accumulator_if.slave         bus
);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_OUT   = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic        [CW-1:0] count_q, count_d;
    logic                 ovf_q, ovf_d;

    logic signed [PW-1:0] w_prod;
    logic signed [AW-1:0] w_ext;
    logic signed [AW-1:0] w_sum;
    logic signed [AW-1:0] w_acc_next;
    logic        [CW-1:0] w_count_inc;
    logic                 w_ovf;
    logic                 w_accept;
    logic                 w_frame_end;

    assign w_prod      = bus.prod_data;
    assign w_ext       = AW'(w_prod);
    assign w_sum       = acc_q + w_ext;
    // Signed overflow: like-signed addends producing a differently-signed sum.
    assign w_ovf       = (acc_q[AW-1] == w_ext[AW-1]) && (w_sum[AW-1] != acc_q[AW-1]);
    assign w_count_inc = count_q + CW'(1);

`ifdef BOOTH_ACC_SAT_EN
    localparam logic signed [AW-1:0] C_ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] C_ACC_MIN = {1'b1, {(AW-1){1'b0}}};
    assign w_acc_next = !w_ovf      ? w_sum :
                        acc_q[AW-1] ? C_ACC_MIN : C_ACC_MAX;
`else
    assign w_acc_next = w_sum;
`endif

    assign bus.prod_ready = (state_q == ST_ACCUM) && !rst;
    assign bus.acc_valid  = (state_q == ST_OUT)   && !rst;
    assign bus.acc_data   = acc_q;
    assign bus.acc_count  = count_q;
    assign bus.acc_ovf    = ovf_q;

    assign w_accept    = bus.prod_valid && bus.prod_ready;
    assign w_frame_end = bus.prod_last || (w_count_inc == CW'(FRAME_LEN));

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_ACCUM: begin
                if (w_accept) begin
                    acc_d   = w_acc_next;
                    count_d = w_count_inc;
                    ovf_d   = ovf_q | w_ovf;
                    if (w_frame_end) begin
                        state_d = ST_OUT;
                    end
                end
            end
            ST_OUT: begin
                if (bus.acc_ready) begin
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACCUM;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_booth_product_accumulator.sv
// ============================================================================
// Module      : tb_booth_product_accumulator
// Description : Scoreboard bench for booth_product_accumulator (AW=16 and AW=8
//               instances; expectations follow BOOTH_ACC_SAT_EN if defined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_booth_product_accumulator;

    typedef struct {
        int data;
        int count;
        int ovf;
    } exp_t;

    logic clk;
    logic rst;

    int n_tests;
    int n_fail;

    exp_t q_exp[2][$];
    int   m_acc[2];
    int   m_cnt[2];
    int   m_ovf[2];

    booth_product_accumulator_if #(.PW(8), .AW(16), .CW(3)) bus16 ();
    booth_product_accumulator_if #(.PW(8), .AW(8),  .CW(3)) bus8  ();

    booth_product_accumulator #(.PW(8), .AW(16), .FRAME_LEN(4)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16.slave)
    );

    booth_product_accumulator #(.PW(8), .AW(8), .FRAME_LEN(4)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic int model_add(input int acc, input int p, input int aw, output int ovf);
        int s;
        int mx;
        int mn;
        s   = acc + p;
        mx  = (1 << (aw - 1)) - 1;
        mn  = -(1 << (aw - 1));
        ovf = 0;
        if (s > mx) begin
            ovf = 1;
`ifdef BOOTH_ACC_SAT_EN
            s = mx;
`else
            s = s - (1 << aw);
`endif
        end else if (s < mn) begin
            ovf = 1;
`ifdef BOOTH_ACC_SAT_EN
            s = mn;
`else
            s = s + (1 << aw);
`endif
        end
        return s;
    endfunction

    task automatic model_clear(input int sel);
        m_acc[sel] = 0;
        m_cnt[sel] = 0;
        m_ovf[sel] = 0;
    endtask

    // Offer one product and hold it until accepted; the model advances on accept.
    task automatic send(input int sel, input int p, input bit last);
        bit   ok;
        int   n;
        int   o;
        exp_t e;
        if (sel == 1) begin
            bus8.prod_valid = 1'b1;  bus8.prod_data = 8'(p);  bus8.prod_last = last;
        end else begin
            bus16.prod_valid = 1'b1; bus16.prod_data = 8'(p); bus16.prod_last = last;
        end
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = (sel == 1) ? bus8.prod_ready : bus16.prod_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (sel == 1) begin
            bus8.prod_valid = 1'b0;  bus8.prod_last = 1'b0;
        end else begin
            bus16.prod_valid = 1'b0; bus16.prod_last = 1'b0;
        end
        if (!ok) begin
            check("send_timeout", 0, 1);
        end else begin
            m_acc[sel] = model_add(m_acc[sel], p, (sel == 1) ? 8 : 16, o);
            m_ovf[sel] = m_ovf[sel] | o;
            m_cnt[sel]++;
            if (last || m_cnt[sel] == 4) begin
                e.data  = m_acc[sel];
                e.count = m_cnt[sel];
                e.ovf   = m_ovf[sel];
                q_exp[sel].push_back(e);
                model_clear(sel);
                check("valid_latency", int'((sel == 1) ? bus8.acc_valid : bus16.acc_valid), 1);
            end
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic monitor(input int sel);
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && ((sel == 1) ? (bus8.acc_valid && bus8.acc_ready)
                                    : (bus16.acc_valid && bus16.acc_ready))) begin
                if (q_exp[sel].size() == 0) begin
                    check("unexpected_frame", 1, 0);
                end else begin
                    e = q_exp[sel].pop_front();
                    if (sel == 1) begin
                        check("acc_data8",   int'(bus8.acc_data),  e.data);
                        check("acc_count8",  int'(bus8.acc_count), e.count);
                        check("acc_ovf8",    int'(bus8.acc_ovf),   e.ovf);
                    end else begin
                        check("acc_data16",  int'(bus16.acc_data),  e.data);
                        check("acc_count16", int'(bus16.acc_count), e.count);
                        check("acc_ovf16",   int'(bus16.acc_ovf),   e.ovf);
                    end
                end
                @(negedge clk);
                if (!rst) begin
                    check("ready_after_hs", int'((sel == 1) ? bus8.prod_ready : bus16.prod_ready), 1);
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        model_clear(0);
        model_clear(1);
        rst = 1'b1;
        bus16.prod_valid = 1'b0; bus16.prod_data = '0; bus16.prod_last = 1'b0; bus16.acc_ready = 1'b1;
        bus8.prod_valid  = 1'b0; bus8.prod_data  = '0; bus8.prod_last  = 1'b0; bus8.acc_ready  = 1'b1;
        idle(3);

        // Reset state
        @(negedge clk);
        check("rst_prod_ready", int'(bus16.prod_ready), 0);
        check("rst_acc_valid",  int'(bus16.acc_valid),  0);
        check("rst_acc_data",   int'(bus16.acc_data),   0);
        check("rst_acc_count",  int'(bus16.acc_count),  0);
        check("rst_acc_ovf",    int'(bus16.acc_ovf),    0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", int'(bus16.prod_ready), 1);
        @(posedge clk);
        #1;

        // Full frame
        send(0, 10, 0); send(0, -3, 0); send(0, 127, 0); send(0, -128, 0);
        idle(2);

        // Early end, then a fresh frame proves the clear
        send(0, 5, 0); send(0, 7, 1);
        send(0, 1, 0); send(0, 1, 0); send(0, 1, 0); send(0, 1, 0);
        idle(2);

        // Backpressure in OUT with a product being offered
        bus16.acc_ready = 1'b0;
        send(0, 1, 0); send(0, 2, 0); send(0, 3, 1);
        for (int i = 0; i < 5; i++) begin
            bus16.prod_valid = 1'b1;
            bus16.prod_data  = 8'd99;
            @(negedge clk);
            check("bp_prod_ready", int'(bus16.prod_ready), 0);
            check("bp_acc_valid",  int'(bus16.acc_valid),  1);
            check("bp_acc_data",   int'(bus16.acc_data),   6);
            check("bp_acc_count",  int'(bus16.acc_count),  3);
            @(posedge clk);
            #1;
        end
        bus16.prod_valid = 1'b0;
        bus16.acc_ready  = 1'b1;
        idle(3);

        // Overflow on the 8-bit accumulator, both directions
        send(1, 100, 0);  send(1, 100, 1);
        idle(2);
        send(1, -100, 0); send(1, -100, 1);
        idle(2);
        send(1, 50, 0); send(1, 20, 1);
        idle(2);

        // Reset mid-frame discards the partial sum
        send(0, 9, 0); send(0, 9, 0); send(0, 9, 0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_prod_ready", int'(bus16.prod_ready), 0);
        check("midrst_acc_valid",  int'(bus16.acc_valid),  0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_clear(0);
        model_clear(1);
        send(0, 2, 0); send(0, 2, 0); send(0, 2, 0); send(0, 2, 0);
        idle(2);

        // Gapped input: idle cycles do not advance the count
        for (int i = 0; i < 4; i++) begin
            send(0, -1, 0);
            if (i < 3) idle(1);
        end
        idle(4);

        check("pending16", q_exp[0].size(), 0);
        check("pending8",  q_exp[1].size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/booth_product_accumulator.md
# booth_product_accumulator

Downstream stage for the 4-bit Booth multiplier. It consumes a stream of signed 8-bit products over a valid/ready handshake and sums each frame of products into a wider signed accumulator. It then presents the frame sum on an output valid/ready handshake. This is the accumulate half of the multiply-accumulate path.

## Interface
Parameters:
- `PW`, 8, product width; two's complement, matches the multiplier's `P`.
- `AW`, 16, accumulator and output width; `AW >= PW`.
- `FRAME_LEN`, 4, maximum number of products per frame; `>= 1`.
- `CW`, `$clog2(FRAME_LEN+1)`, width of the count output (derived parameter).

Ports:
- `clk`, input, 1, the single clock; all state changes on the rising edge.
- `rst`, input, 1, reset; synchronous and active-high.
- `prod_valid`, input, 1, a product is offered.
- `prod_ready`, output, 1, the block accepts a product this cycle.
- `prod_data`, input, PW, signed product.
- `prod_last`, input, 1, the accepted product closes the frame early.
- `acc_valid`, output, 1, a frame sum is available.
- `acc_ready`, input, 1, the consumer takes the frame sum.
- `acc_data`, output, AW, signed frame sum.
- `acc_count`, output, CW, number of products in the presented frame (1..FRAME_LEN).
- `acc_ovf`, output, 1, signed overflow occurred in the presented frame.

## Operation
- Two-state FSM: ACCUM and OUT. Reset state is ACCUM.
- **ACCUM**
  - `prod_ready = 1` and `acc_valid = 0`.
  - Accept occurs when `prod_valid & prod_ready`.
  - On accept, the accumulator becomes the accumulator plus `prod_data` sign-extended to AW, and the count increments.
- **Frame end**
  - The frame ends on the accept where the count reaches FRAME_LEN, or on an accept with `prod_last = 1`, whichever comes first.
  - At frame end the next state is OUT.
  - `prod_last` is ignored when no accept occurs.
- **OUT**
  - `prod_ready = 0`; `prod_valid` and `prod_data` are ignored.
  - `acc_valid = 1`; `acc_data`, `acc_count` and `acc_ovf` stay stable until handshake.
  - On `acc_valid & acc_ready`, the accumulator, count and overflow flag clear to 0 and the next state is ACCUM.
- **Overflow detect**
  - Overflow is flagged when both addends have equal sign bits and the sum's sign bit differs.
  - `acc_ovf` is sticky for the frame.
- **Arithmetic:** all arithmetic is two's complement modulo 2^AW unless `BOOTH_ACC_SAT_EN` is defined (see Configuration).
- **Reset values**
  - The accumulator, count, `acc_data`, `acc_count` and `acc_ovf` are 0.
  - `acc_valid` is 0.
  - `prod_ready` is 0 while `rst` is high, and 1 from the first cycle after `rst` falls.
  - Reset mid-frame or in OUT discards the partial or pending sum; no output handshake completes in the reset cycle.

## Timing
- Throughput in ACCUM is one product per cycle, with no bubbles between accepts.
- If the final product is accepted at edge t, `acc_valid` rises in the cycle after edge t and `acc_data` already includes that product.
- The OUT state lasts at least one cycle. A frame of k products therefore occupies at least k+1 cycles.
- After the output handshake at edge u, `prod_ready` is 1 in the cycle after edge u.
- There is no combinational path from `prod_valid` or `acc_ready` to any output. `prod_ready` and `acc_valid` decode only from state and `rst`.

## Configuration
- `BOOTH_ACC_SAT_EN` defined:
  - On overflow, the accumulator clamps to +(2^(AW-1)-1) for positive overflow or -2^(AW-1) for negative overflow.
  - `acc_ovf` is set.
  - Later adds in the frame start from the clamped value.
- `BOOTH_ACC_SAT_EN` undefined:
  - The accumulator wraps modulo 2^AW.
  - `acc_ovf` is still set.
- No other behaviour differs.

## Test plan
- **Full frame** (defaults): products 10, -3, 127, -128 on consecutive cycles with `acc_ready = 1` -> `acc_valid` one cycle after the 4th accept with `acc_data = 6`, `acc_count = 4`, `acc_ovf = 0`; `prod_ready` returns to 1 on the next cycle.
- **Early end:** products 5 then 7 with `prod_last = 1` on the second -> `acc_data = 12`, `acc_count = 2`; a following frame of 1, 1, 1, 1 -> `acc_data = 4`, showing the clear worked.
- **Backpressure:** hold `acc_ready = 0` for 5 cycles in OUT while driving `prod_valid = 1` with data 99 -> `acc_data`, `acc_count` and `acc_valid` stay stable, `prod_ready = 0`, and 99 is never summed.
- **Overflow:** with `AW = 8`, products 100 then 100 with `prod_last` -> without the macro `acc_data = -56`, `acc_ovf = 1`; with `BOOTH_ACC_SAT_EN` `acc_data = 127`, `acc_ovf = 1`; repeat with -100, -100 expecting -128 saturated.
- **Reset mid-frame:** accept 3 products, assert `rst` for 1 cycle, then send 2, 2, 2, 2 -> sum is 8 and count is 4; `acc_valid` never pulses for the aborted frame.
- **Gapped input:** `prod_valid` toggles 1,0,1,0,... over four products of -1 -> `acc_data = -4` (0xFFFC at AW = 16); idle cycles do not change the count.
